// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: parameter defaults and the
// launch FSM state encoding.
package uart_tx_feeder_pkg;

    localparam int FEEDER_DATA_WIDTH = 8;
    localparam int FEEDER_DEPTH      = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer. The head is presented combinationally and popped on rd_en.
// Writes made while the buffer is full are dropped and set a sticky overflow flag.
module uart_tx_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = FEEDER_DATA_WIDTH,
    parameter int DEPTH      = FEEDER_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_ok, rd_ok;

    // The extra pointer MSB tells a full buffer apart from an empty one.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow   = overflow_q;

    always_comb begin
        wr_ok      = wr_en && !full;
        rd_ok      = rd_en && !empty;
        wr_ptr_d   = wr_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = rd_ok ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        overflow_d = overflow_q || (wr_en && full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them one at a time into a UART transmitter,
// using a one-cycle tx_data_valid pulse and the transmitter's tx_busy handshake.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = FEEDER_DATA_WIDTH,
    parameter int DEPTH      = FEEDER_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    input  logic                     tx_busy,
    output logic [DATA_WIDTH-1:0]    tx_p_data,
    output logic                     tx_data_valid
);
    feeder_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
    logic                  tx_data_valid_q, tx_data_valid_d;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .rd_en      (pop),
        .rd_data    (head_data),
        .full       (full),
        .empty      (empty),
        .fill_level (fill_level),
        .overflow   (overflow)
    );

    always_comb begin
        state_d     = state_q;
        tx_p_data_d = tx_p_data_q;
        pop         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_d     = ST_LAUNCH;
                    tx_p_data_d = head_data;
                    pop         = 1'b1;
                end
            end
            ST_LAUNCH:    state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        // Registered so the pulse coincides exactly with the LAUNCH cycle.
        tx_data_valid_d = (state_d == ST_LAUNCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            tx_p_data_q     <= '0;
            tx_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tx_p_data_q     <= tx_p_data_d;
            tx_data_valid_q <= tx_data_valid_d;
        end
    end

    assign tx_p_data     = tx_p_data_q;
    assign tx_data_valid = tx_data_valid_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple UART busy model.
module tb_uart_tx_feeder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full, empty, overflow;
    logic [3:0] fill_level;
    logic       tx_busy;
    logic [7:0] tx_p_data;
    logic       tx_data_valid;

    logic       model_busy = 1'b0;
    logic       hold_busy;
    logic       pend = 1'b0;
    logic       prev_vld = 1'b0;
    int         busy_cnt = 0;
    int         pulse_cnt = 0;
    int         double_pulse = 0;
    logic [7:0] rx_q [$];

    int n_checks = 0;
    int n_errs   = 0;

    assign tx_busy = model_busy | hold_busy;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .full          (full),
        .empty         (empty),
        .fill_level    (fill_level),
        .overflow      (overflow),
        .tx_busy       (tx_busy),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid)
    );

    // Transmitter model: busy rises one cycle after the launch pulse, stays high 11 cycles.
    always @(negedge clk) begin
        if (tx_data_valid) begin
            rx_q.push_back(tx_p_data);
            pulse_cnt++;
            if (prev_vld) double_pulse++;
            pend = 1'b1;
        end else if (pend) begin
            pend       = 1'b0;
            model_busy = 1'b1;
            busy_cnt   = 11;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end
        prev_vld = tx_data_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        int budget;
        budget = 2000;
        while (!(rx_q.size() >= n && !model_busy && !pend && empty && !tx_data_valid)
               && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
        cyc(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        int p0;
        int sent;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        hold_busy = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_vld", tx_data_valid, 0);
        chk("rst_data", tx_p_data, 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Single byte, latency and pop.
        p0 = pulse_cnt;
        rx_q.delete();
        put(8'hA5);
        chk("lat_n_vld", tx_data_valid, 0);
        chk("lat_n_fill", fill_level, 1);
        cyc(1);
        chk("lat_n1_vld", tx_data_valid, 1);
        chk("lat_n1_data", tx_p_data, 8'hA5);
        chk("lat_n1_empty", empty, 1);
        cyc(1);
        chk("pulse_width", tx_data_valid, 0);
        chk("data_stable", tx_p_data, 8'hA5);
        drain(1, "single");
        chk("single_pulses", pulse_cnt - p0, 1);
        chk("single_rx", rx_q[0], 8'hA5);

        // Fill to full with the transmitter held busy, then overflow.
        p0 = pulse_cnt;
        rx_q.delete();
        hold_busy = 1'b1;
        wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("full_flag", full, 1);
        chk("full_fill", fill_level, 8);
        chk("full_noovf", overflow, 0);
        chk("busy_idle_nolaunch", pulse_cnt - p0, 0);
        put(8'hFF);
        chk("ovf_set", overflow, 1);
        chk("ovf_fill", fill_level, 8);
        hold_busy = 1'b0;
        drain(8, "full");
        chk("full_count", rx_q.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("full_order%0d", i), rx_q[i], 32'(i + 1));
        chk("ovf_sticky", overflow, 1);
        do_reset();
        chk("ovf_cleared", overflow, 0);

        // Launch held off by an external frame.
        p0 = pulse_cnt;
        rx_q.delete();
        hold_busy = 1'b1;
        put(8'h3C);
        cyc(5);
        chk("hold_nopulse", pulse_cnt - p0, 0);
        chk("hold_fill", fill_level, 1);
        hold_busy = 1'b0;
        chk("hold_drop_vld", tx_data_valid, 0);
        cyc(1);
        chk("hold_launch_vld", tx_data_valid, 1);
        chk("hold_launch_data", tx_p_data, 8'h3C);
        drain(1, "hold");
        chk("hold_rx", rx_q[0], 8'h3C);

        // Write and pop on the same edge at fill_level 3.
        rx_q.delete();
        hold_busy = 1'b1;
        put(8'h66);
        put(8'h11);
        put(8'h22);
        chk("simul_pre_fill", fill_level, 3);
        hold_busy = 1'b0;
        put(8'h77);
        chk("simul_fill", fill_level, 3);
        chk("simul_vld", tx_data_valid, 1);
        chk("simul_data", tx_p_data, 8'h66);
        drain(4, "simul");
        chk("simul_o0", rx_q[0], 8'h66);
        chk("simul_o1", rx_q[1], 8'h11);
        chk("simul_o2", rx_q[2], 8'h22);
        chk("simul_o3", rx_q[3], 8'h77);

        // Asynchronous reset while a frame is in flight with 4 bytes queued.
        rx_q.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) put(8'hC0 + 8'(i));
        hold_busy = 1'b0;
        for (int b = 0; b < 100 && !model_busy; b++) @(negedge clk);
        chk("midrst_busy_seen", model_busy, 1);
        cyc(3);
        chk("midrst_queued", fill_level, 4);
        p0 = pulse_cnt;
        #2 rst = 1'b1;
        #1;
        chk("midrst_vld", tx_data_valid, 0);
        chk("midrst_data", tx_p_data, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_fill", fill_level, 0);
        chk("midrst_full", full, 0);
        cyc(2);
        rst = 1'b0;
        cyc(40);
        chk("midrst_nopulse", pulse_cnt - p0, 0);
        chk("midrst_still_empty", empty, 1);

        // Stream 20 bytes through the 8-entry buffer, pacing on full.
        rx_q.delete();
        sent = 0;
        while (sent < 20) begin
            if (!full) begin
                wr_data = 8'h40 + 8'(sent);
                wr_en   = 1'b1;
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        drain(20, "wrap");
        chk("wrap_count", rx_q.size(), 20);
        for (int i = 0; i < 20; i++)
            chk($sformatf("wrap_o%0d", i), rx_q[i], 32'(8'h40 + i));
        chk("wrap_noovf", overflow, 0);
        chk("no_double_pulse", double_pulse, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
